pb_conditioner: RTL and testbench

- Input stage for the Tug of War game. Sits between the raw pushbuttons (pbl, pbr) and the game FSM inside top.
- Each button gets a synchroniser, a debounce filter and a rising-edge detector. Each press is latched as pending.
- A pending press is released as a single-cycle pulse aligned to the game's slow-enable strobe, so the FSM sees each physical press exactly once.
- Presses made during the dark state are latched too, so jump-the-gun detection works in the game FSM.

---
 rtl/pb_conditioner.sv | 150 +++++++++++++++
 tb/tb_pb_conditioner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pb_conditioner.sv
// ============================================================================
//  Module      : pb_conditioner
//  Description : Pushbutton input stage for the Tug of War game. Each of the
//                two raw buttons passes through a 2-FF synchroniser, a
//                counter-based debounce filter and a rising-edge detector.
//                A detected press is held as pending and then released to
//                the game FSM as a single-cycle pulse on the next slow_en
//                strobe. The FSM therefore sees each physical press exactly
//                once, including presses made before the go signal.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEB_CYCLES : consecutive cycles the synchronised level must differ from
//                 the debounced level before the debounced level follows it
//                 (legal range 1..255)
//    CNT_W      : debounce counter width, 2**CNT_W must exceed DEB_CYCLES
//  Ports
//    clk        in   system clock, all state updates on its rising edge
//    rst        in   asynchronous active-high reset, clears all state
//    slow_en    in   single-cycle strobe from the game slow-enable divider
//    pbl        in   raw left pushbutton, asynchronous, active-high
//    pbr        in   raw right pushbutton, asynchronous, active-high
//    pbl_press  out  one-cycle registered pulse per left press
//    pbr_press  out  one-cycle registered pulse per right press
//    pbl_level  out  debounced left button level
//    pbr_level  out  debounced right button level
// ============================================================================
`default_nettype none

module pb_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic slow_en,
    input  logic pbl,
    input  logic pbr,
    output logic pbl_press,
    output logic pbr_press,
    output logic pbl_level,
    output logic pbr_level
);

    // Terminal count of the debounce counter: when the synchronised input has
    // disagreed with the debounced level for this many prior cycles, the
    // disagreement on the current edge is the DEB_CYCLES-th in a row.
    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    // Channel 0 is the left button, channel 1 the right button.
    logic [1:0] w_raw;
    logic [1:0] w_press;
    logic [1:0] w_level;

    assign w_raw = {pbr, pbl};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_chan
            logic             r_s1;      // first synchroniser stage
            logic             r_s;       // synchronised button level
            logic [CNT_W-1:0] r_cnt;     // consecutive-disagreement counter
            logic             r_level;   // debounced button level
            logic             r_pend;    // press detected, not yet delivered
            logic             r_press;   // registered press pulse

            logic             w_differ;
            logic             w_cnt_done;
            logic             w_update;
            logic             w_rise;
            logic             w_release;

            // ---------------------------------------------------------------
            // Synchroniser: raw -> r_s1 -> r_s
            // ---------------------------------------------------------------
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1 <= 1'b0;
                    r_s  <= 1'b0;
                end else begin
                    r_s1 <= w_raw[g];
                    r_s  <= r_s1;
                end
            end

            // ---------------------------------------------------------------
            // Debounce filter. Any cycle where the synchronised input agrees
            // with the debounced level restarts the count, so a glitch must
            // persist for DEB_CYCLES consecutive samples to be accepted.
            // ---------------------------------------------------------------
            assign w_differ   = (r_s != r_level);
            assign w_cnt_done = (r_cnt == c_DEB_LAST);
            assign w_update   = w_differ && w_cnt_done;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (!w_differ) begin
                    r_cnt   <= '0;
                end else if (w_cnt_done) begin
                    r_level <= r_s;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end

            // ---------------------------------------------------------------
            // Edge detect, pending latch and release.
            // w_rise fires on the edge where the debounced level goes 0->1,
            // so the pending flag is set in the same cycle the level rises.
            // A held button cannot re-trigger because the level stays 1.
            // Release uses the pending value from before the edge, so a press
            // that becomes pending on a slow_en edge waits for the next one.
            // If a new press arrives on the very edge that delivers the old
            // one, the new press is kept rather than dropped.
            // A falling level never clears pending: a short press that has
            // already been accepted is still delivered.
            // ---------------------------------------------------------------
            assign w_rise    = w_update && r_s;
            assign w_release = slow_en && r_pend;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pend  <= 1'b0;
                    r_press <= 1'b0;
                end else begin
                    r_press <= w_release;
                    if (w_rise) begin
                        r_pend <= 1'b1;
                    end else if (w_release) begin
                        r_pend <= 1'b0;
                    end
                end
            end

            assign w_press[g] = r_press;
            assign w_level[g] = r_level;
        end
    endgenerate

    // All outputs come straight from flops: no combinational input->output path.
    assign pbl_press = w_press[0];
    assign pbr_press = w_press[1];
    assign pbl_level = w_level[0];
    assign pbr_level = w_level[1];

endmodule

`default_nettype wire

// File: tb/tb_pb_conditioner.sv
// ============================================================================
//  Module      : tb_pb_conditioner
//  Description : Self-checking bench for pb_conditioner. Stimulus pushes the
//                expected press pulses (edge number and channel bits) into a
//                scoreboard queue; a monitor pops and compares whenever the
//                DUT presents a press pulse. Level and reset checks are made
//                directly from the stimulus thread.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports       : none (top-level bench)
// ============================================================================
`default_nettype none

module tb_pb_conditioner;

    localparam int c_DEB = 4;

    logic clk;
    logic rst;
    logic slow_en;
    logic pbl;
    logic pbr;
    logic pbl_press;
    logic pbr_press;
    logic pbl_level;
    logic pbr_level;

    pb_conditioner #(
        .DEB_CYCLES (c_DEB),
        .CNT_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .slow_en   (slow_en),
        .pbl       (pbl),
        .pbr       (pbr),
        .pbl_press (pbl_press),
        .pbr_press (pbr_press),
        .pbl_level (pbl_level),
        .pbr_level (pbr_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   edge_no;
        logic l;
        logic r;
    } exp_t;

    exp_t sb[$];

    int n_edge  = 0;
    int n_check = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_check++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts rising edges and samples outputs 1 time unit later.
    always @(posedge clk) begin
        exp_t e;
        n_edge = n_edge + 1;
        #1;
        if (pbl_press || pbr_press) begin
            if (sb.size() == 0) begin
                check("unexpected_press", int'({pbl_press, pbr_press}), 0);
            end else begin
                e = sb.pop_front();
                check("press_edge", n_edge, e.edge_no);
                check("press_l", int'(pbl_press), int'(e.l));
                check("press_r", int'(pbr_press), int'(e.r));
            end
        end
    end

    task automatic idle(input int n);
        pbl     = 1'b0;
        pbr     = 1'b0;
        slow_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // At iteration k of each test loop the DUT has seen base+k edges; inputs
    // set in iteration k are sampled by edge base+k+1 ("spec edge k").
    initial begin
        int base;
        int seen_hi;

        rst     = 1'b1;
        slow_en = 1'b0;
        pbl     = 1'b0;
        pbr     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pbl_press", int'(pbl_press), 0);
        check("rst_pbr_press", int'(pbr_press), 0);
        check("rst_pbl_level", int'(pbl_level), 0);
        check("rst_pbr_level", int'(pbr_level), 0);
        rst = 1'b0;
        idle(4);

        // Test 1: pbr held 5 cycles, slow_en every 4th cycle. Level rises
        // after spec edge 5 (base+6); first slow_en after that is k=7.
        base = n_edge;
        sb.push_back('{base + 8, 1'b0, 1'b1});
        for (int k = 0; k < 20; k++) begin
            pbr     = (k < 5);
            slow_en = ((k % 4) == 3);
            if (k == 5) check("t1_level_before", int'(pbr_level), 0);
            if (k == 6) check("t1_level_after", int'(pbr_level), 1);
            @(negedge clk);
        end
        idle(10);

        // Test 2: 3-cycle glitch on pbl with slow_en constant -> nothing.
        base    = n_edge;
        seen_hi = 0;
        for (int k = 0; k < 15; k++) begin
            pbl     = (k < 3);
            slow_en = 1'b1;
            if (pbl_level) seen_hi = 1;
            @(negedge clk);
        end
        check("t2_glitch_level", seen_hi, 0);
        idle(5);

        // Test 3: pbl held 40 cycles, slow_en constant. Pending at base+6,
        // delivered on base+7. Release before spec edge 40 -> level falls
        // after spec edge 45 (base+46).
        base = n_edge;
        sb.push_back('{base + 7, 1'b1, 1'b0});
        for (int k = 0; k < 50; k++) begin
            pbl     = (k < 40);
            slow_en = 1'b1;
            if (k == 45) check("t3_level_held", int'(pbl_level), 1);
            if (k == 46) check("t3_level_fall", int'(pbl_level), 0);
            @(negedge clk);
        end
        idle(10);

        // Test 4: both pressed together, slow_en every 8th cycle -> one
        // simultaneous pulse at base+8.
        base = n_edge;
        sb.push_back('{base + 8, 1'b1, 1'b1});
        for (int k = 0; k < 25; k++) begin
            pbl     = (k < 10);
            pbr     = (k < 10);
            slow_en = ((k % 8) == 7);
            @(negedge clk);
        end
        idle(10);

        // Test 5: pbr pending with slow_en idle for 20 cycles, then one
        // strobe (k=20 -> base+21), then a further strobe gives nothing.
        base = n_edge;
        sb.push_back('{base + 21, 1'b0, 1'b1});
        for (int k = 0; k < 35; k++) begin
            pbr     = (k < 10);
            slow_en = (k == 20) || (k == 25);
            if (k == 18) check("t5_level_fell", int'(pbr_level), 0);
            @(negedge clk);
        end
        idle(10);

        // Test 6: press pending, async reset mid-cycle, release with the
        // button up -> outputs clear at once and no pulse is ever emitted.
        base = n_edge;
        for (int k = 0; k < 10; k++) begin
            pbr     = 1'b1;
            slow_en = 1'b0;
            @(negedge clk);
        end
        check("t6_level_pre_rst", int'(pbr_level), 1);
        pbr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_pbl_press", int'(pbl_press), 0);
        check("t6_rst_pbr_press", int'(pbr_press), 0);
        check("t6_rst_pbl_level", int'(pbl_level), 0);
        check("t6_rst_pbr_level", int'(pbr_level), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            slow_en = 1'b1;
            @(negedge clk);
        end
        check("t6_level_post", int'(pbr_level), 0);
        idle(3);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule

`default_nettype wire
